// File: rtl/exc_ctrl_if.sv
// Memory-stage handshake and fetch redirect channel for exc_ctrl.
// The master drives the instruction/event stream; the slave (exc_ctrl) drives the redirect.
interface exc_ctrl_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_pc;
  logic        m_in_delay;
  logic [15:0] m_exc;
  logic [31:0] m_badvaddr;
  logic        m_eret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output m_valid, m_pc, m_in_delay, m_exc, m_badvaddr, m_eret, redirect_ready,
    input  m_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  m_valid, m_pc, m_in_delay, m_exc, m_badvaddr, m_eret, redirect_ready,
    output m_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt/eret commit controller: IDLE -> COMMIT (one cycle) -> REDIRECT.
// Define EXC_TLB_REFILL_VEC_EN to route TLB refills (SR_EXL=0) to offset 0x000.
module exc_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  exc_ctrl_if.slave   bus,
  input  logic        allow_int,
  input  logic [7:0]  interrupt_flag,
  input  logic        SR_BEV,
  input  logic        SR_EXL,
  input  logic        CAUSE_IV,
  input  logic [31:0] ebase,
  input  logic [31:0] epc,
  output logic        en_exp,
  output logic        exp_bd,
  output logic [31:0] exp_epc,
  output logic [4:0]  ExcCode,
  output logic [31:0] exp_badvaddr,
  output logic        exp_badvaddr_we,
  output logic        clear_exl,
  output logic        flush
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {EV_NONE, EV_INT, EV_EXC, EV_ERET} ev_t;

  state_t      state, state_nxt;
  ev_t         ev_d, ev_q;
  logic [3:0]  exc_idx_d, exc_idx_q;
  logic [31:0] pc_q, badvaddr_q, ebase_q, epc_q;
  logic        in_delay_q, bev_q, exl_q, iv_q;
  logic        transfer, take;
  logic [4:0]  exc_code;
  logic [31:0] vec_base, vec_off, target;

  // Interrupt beats every m_exc bit; lowest m_exc index beats higher ones; eret last.
  always_comb begin
    ev_d      = EV_NONE;
    exc_idx_d = '0;
    if (allow_int && |interrupt_flag) begin
      ev_d = EV_INT;
    end else if (|bus.m_exc) begin
      ev_d = EV_EXC;
      for (int unsigned i = 16; i > 0; i--) begin
        if (bus.m_exc[i-1]) exc_idx_d = 4'(i-1);
      end
    end else if (bus.m_eret) begin
      ev_d = EV_ERET;
    end
  end

  assign transfer = bus.m_valid && bus.m_ready;
  assign take     = (state == IDLE) && transfer && (ev_d != EV_NONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take) state_nxt = COMMIT;
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: if (bus.redirect_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ev_q       <= EV_NONE;
      exc_idx_q  <= '0;
      pc_q       <= '0;
      badvaddr_q <= '0;
      ebase_q    <= '0;
      epc_q      <= '0;
      in_delay_q <= 1'b0;
      bev_q      <= 1'b0;
      exl_q      <= 1'b0;
      iv_q       <= 1'b0;
    end else if (take) begin
      ev_q       <= ev_d;
      exc_idx_q  <= exc_idx_d;
      pc_q       <= bus.m_pc;
      badvaddr_q <= bus.m_badvaddr;
      ebase_q    <= ebase;
      epc_q      <= epc;
      in_delay_q <= bus.m_in_delay;
      bev_q      <= SR_BEV;
      exl_q      <= SR_EXL;
      iv_q       <= CAUSE_IV;
    end
  end

  always_comb begin
    case (exc_idx_q)
      4'd0, 4'd9:                exc_code = 5'd4;
      4'd1, 4'd2, 4'd11, 4'd13:  exc_code = 5'd2;
      4'd3:                      exc_code = 5'd10;
      4'd4:                      exc_code = 5'd11;
      4'd5:                      exc_code = 5'd12;
      4'd6:                      exc_code = 5'd13;
      4'd7:                      exc_code = 5'd8;
      4'd8:                      exc_code = 5'd9;
      4'd10:                     exc_code = 5'd5;
      4'd12, 4'd14:              exc_code = 5'd3;
      default:                   exc_code = 5'd1;
    endcase
  end

  assign vec_base = bev_q ? (RESET_VEC + 32'h200) : ebase_q;

`ifdef EXC_TLB_REFILL_VEC_EN
  logic refill;
  assign refill = (ev_q == EV_EXC) && !exl_q &&
                  ((exc_idx_q == 4'd1) || (exc_idx_q == 4'd11) || (exc_idx_q == 4'd12));
  assign vec_off = refill ? 32'h000 : ((ev_q == EV_INT) && iv_q) ? 32'h200 : 32'h180;
`else
  assign vec_off = ((ev_q == EV_INT) && iv_q) ? 32'h200 : 32'h180;
`endif

  assign target = (ev_q == EV_ERET) ? epc_q : (vec_base + vec_off);

  always_comb begin
    bus.m_ready        = (state == IDLE);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    en_exp             = 1'b0;
    exp_bd             = 1'b0;
    exp_epc            = '0;
    ExcCode            = '0;
    exp_badvaddr       = '0;
    exp_badvaddr_we    = 1'b0;
    clear_exl          = 1'b0;
    flush              = 1'b0;
    case (state)
      COMMIT: begin
        flush = 1'b1;
        if (ev_q == EV_ERET) begin
          clear_exl = 1'b1;
        end else begin
          en_exp  = 1'b1;
          exp_bd  = in_delay_q;
          exp_epc = exl_q ? epc_q : (in_delay_q ? pc_q - 32'd4 : pc_q);
          if (ev_q == EV_EXC) begin
            ExcCode = exc_code;
            if (exc_idx_q <= 4'd2) begin
              exp_badvaddr_we = 1'b1;
              exp_badvaddr    = pc_q;
            end else if (exc_idx_q >= 4'd9) begin
              exp_badvaddr_we = 1'b1;
              exp_badvaddr    = badvaddr_q;
            end
          end
        end
      end
      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_VEC, default 32'hBFC0_0000, which is the base from which the boot vector (BEV=1) is derived.
REQ-002 The block SHALL have these ports: clk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have these ports: resetn, in, 1, asynchronous active-low reset.
REQ-004 The block SHALL have these memory-stage ports: m_valid in 1; m_ready out 1; m_pc in 32; m_in_delay in 1; m_exc in 16; m_badvaddr in 32; m_eret in 1.
REQ-005 The block SHALL have these CP0 status inputs: allow_int in 1; interrupt_flag in 8; SR_BEV in 1; SR_EXL in 1; CAUSE_IV in 1; ebase in 32; epc in 32.
REQ-006 The block SHALL have these CP0 commit outputs: en_exp out 1; exp_bd out 1; exp_epc out 32; ExcCode out 5; exp_badvaddr out 32; exp_badvaddr_we out 1; clear_exl out 1.
REQ-007 The block SHALL have these pipeline outputs: flush out 1; redirect_valid out 1; redirect_pc out 32.
REQ-008 The block SHALL have input redirect_ready, 1 bit, which is the fetch-side acceptance of the redirect.

Function
REQ-009 The FSM SHALL have three states: IDLE, COMMIT and REDIRECT.
REQ-010 m_ready SHALL be 1 only in IDLE.
REQ-011 A memory-stage transfer SHALL occur when m_valid and m_ready are both 1.
REQ-012 In IDLE, a transfer SHALL move the FSM to COMMIT if an event is present: an interrupt (allow_int and |interrupt_flag), any m_exc bit, or m_eret. Otherwise the FSM SHALL stay in IDLE.
REQ-013 Event priority SHALL be: interrupt > m_exc[0] > m_exc[1] > ... > m_exc[15] > m_eret.
REQ-014 m_exc bit-to-ExcCode mapping SHALL be:
- [0] AdEL-fetch = 4
- [1] TLBL-refill-fetch = 2
- [2] TLBL-invalid-fetch = 2
- [3] RI = 10
- [4] CpU = 11
- [5] Ov = 12
- [6] Tr = 13
- [7] Sys = 8
- [8] Bp = 9
- [9] AdEL-data = 4
- [10] AdES = 5
- [11] TLBL-refill-data = 2
- [12] TLBS-refill = 3
- [13] TLBL-invalid-data = 2
- [14] TLBS-invalid = 3
- [15] Mod = 1
- interrupt = 0
REQ-015 The block SHALL latch the winning event, m_pc, m_in_delay, m_badvaddr and all CP0 status inputs on the IDLE->COMMIT edge.
REQ-016 COMMIT SHALL last exactly one cycle. For an exception or interrupt it SHALL pulse en_exp=1. For an eret it SHALL pulse clear_exl=1. flush SHALL be 1 in both cases. The FSM SHALL then go to REDIRECT.
REQ-017 exp_epc SHALL be m_pc-4 if m_in_delay, else m_pc, computed mod 2^32.
REQ-018 exp_bd SHALL equal m_in_delay.
REQ-019 If the latched SR_EXL=1, exp_epc SHALL be the latched epc instead of the value in REQ-017.
REQ-020 exp_badvaddr_we SHALL be 1 for bits [0..2], with exp_badvaddr=m_pc.
REQ-021 exp_badvaddr_we SHALL be 1 for bits [9..15], with exp_badvaddr=m_badvaddr.
REQ-022 exp_badvaddr_we SHALL be 0 otherwise.
REQ-023 The exception target SHALL be base+offset.
- base = RESET_VEC+32'h200 if SR_BEV, else ebase.
- offset = 0x000 for a refill (REQ-037) with SR_EXL=0; 0x200 for an interrupt with CAUSE_IV=1; otherwise 0x180.
REQ-024 The eret target SHALL be the latched epc.
REQ-025 In REDIRECT, redirect_valid=1 and redirect_pc SHALL hold stable until redirect_ready=1. The FSM SHALL go to IDLE on the cycle after redirect_ready is seen.
REQ-026 redirect_ready=1 in the first REDIRECT cycle SHALL give a single-cycle REDIRECT.
REQ-027 Commit outputs SHALL be zero outside COMMIT.
REQ-028 flush SHALL be zero outside COMMIT.
REQ-029 redirect_valid SHALL be zero outside REDIRECT.
REQ-030 An exception and m_eret in the same transfer SHALL take the exception; eret is ignored.
REQ-031 When an interrupt is pending, ExcCode=0 and EPC SHALL refer to the instruction at m_pc (that instruction is not executed).
REQ-032 Latency from the event transfer to redirect_valid SHALL be 2 cycles.

Reset
REQ-033 On resetn=0, regardless of state, the FSM SHALL go to IDLE immediately.
REQ-034 During and after reset, all outputs SHALL be 0 except m_ready=1.
REQ-035 During and after reset, all latched registers SHALL be 0.
REQ-036 Reset asserted mid-COMMIT or mid-REDIRECT SHALL abandon the event; no pulse is re-issued after release.

Configuration
REQ-037 Macro EXC_TLB_REFILL_VEC_EN SHALL control the refill vector.
- Defined: m_exc bits 1, 11 and 12 with SR_EXL=0 use offset 0x000.
- Undefined: every exception, refill included, uses offset 0x180 (interrupt IV rule unchanged); no refill decode logic is synthesised.

Verification
REQ-038 Sys: SR_BEV=0, ebase=32'h8000_0000, m_exc[7]=1, m_pc=32'h8000_1000, m_in_delay=0. Required: en_exp pulse, ExcCode=8, exp_epc=32'h8000_1000, exp_badvaddr_we=0; redirect_pc=32'h8000_0180 two cycles after the transfer.
REQ-039 Delay-slot data refill: m_exc[11]=1, m_in_delay=1, m_pc=32'h0040_0008, m_badvaddr=32'h0000_1234, SR_EXL=0. Required: exp_epc=32'h0040_0004, exp_bd=1, ExcCode=2, exp_badvaddr=32'h0000_1234. redirect_pc=32'h8000_0000 with the macro, 32'h8000_0180 without it.
REQ-040 Interrupt vs. exception: allow_int=1, interrupt_flag=8'h80, CAUSE_IV=1, plus m_exc[5]=1. Required: ExcCode=0, redirect_pc=ebase+32'h200.
REQ-041 Eret: m_eret=1 and epc=32'hBFC0_0380. Required: clear_exl pulse and no en_exp; redirect_pc=32'hBFC0_0380. Hold redirect_ready=0 for 3 cycles: redirect_valid stays 1, m_ready stays 0.
REQ-042 BEV with SR_EXL=1: SR_BEV=1, SR_EXL=1, m_exc[1]=1. Required: redirect_pc=32'hBFC0_0380, exp_epc equals the latched epc input.
REQ-043 Reset mid-REDIRECT: drop resetn. Required: redirect_valid=0 and m_ready=1 immediately; no en_exp pulse after release.
